// File: rtl/logic_done_gen_pkg.sv
// Shared types for the cache completion timer: chain identifiers and routing helper.
package logic_done_gen_pkg;

    typedef enum logic [1:0] {
        CH_RD_HIT  = 2'd0,
        CH_RD_MISS = 2'd1,
        CH_WR_HIT  = 2'd2,
        CH_WR_MISS = 2'd3
    } chain_e;

    // Read wins over write when both are requested in the same cycle.
    function automatic chain_e route_chain(input logic re, input logic hit);
        if (re) return hit ? CH_RD_HIT : CH_RD_MISS;
        else    return hit ? CH_WR_HIT : CH_WR_MISS;
    endfunction

endpackage

// File: rtl/logic_done_gen_if.sv
// CPU-side request/completion signals of the cache completion timer.
interface logic_done_gen_if;
    logic we;
    logic re;
    logic hit;
    logic pre_done;
    logic done;

    modport master (output we, output re, output hit, input pre_done, input done);
    modport slave  (input we, input re, input hit, output pre_done, output done);
endinterface

// File: rtl/logic_done_gen_delay_line.sv
// 1-bit shift register with every stage exposed; async active-low reset clears all stages.
module delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic all_out [0:DEPTH-1]
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) all_out[i] <= 1'b0;
        end else begin
            all_out[0] <= din;
            for (int i = 1; i < DEPTH; i++) all_out[i] <= all_out[i-1];
        end
    end
endmodule

// File: rtl/logic_done_gen.sv
// Completion timer: one accepted request walks a hit or miss chain; pre_done/done taken
// from the last two stages. Requests arriving while any chain is busy are ignored.
module logic_done_gen
    import logic_done_gen_pkg::*;
#(
    parameter int MIN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    logic_done_gen_if.slave  bus
);
    localparam int H = MIN_CYCLES + 1;
    localparam int M = MIN_CYCLES + 2;

    generate
        if (MIN_CYCLES < 1) begin : g_bad_param
            $error("logic_done_gen: MIN_CYCLES must be >= 1");
        end
    endgenerate

    logic read_hit_delay_all_out   [0:H-1];
    logic read_miss_delay_all_out  [0:M-1];
    logic write_hit_delay_all_out  [0:H-1];
    logic write_miss_delay_all_out [0:M-1];

    logic   busy;
    logic   start;
    chain_e sel;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < H; i++)
            busy = busy | read_hit_delay_all_out[i] | write_hit_delay_all_out[i];
        for (int i = 0; i < M; i++)
            busy = busy | read_miss_delay_all_out[i] | write_miss_delay_all_out[i];
    end

    assign start = (bus.re | bus.we) & ~busy;
    assign sel   = route_chain(bus.re, bus.hit);

    delay_line #(.DEPTH(H)) u_read_hit (
        .clk(clk), .rst(rst), .din(start & (sel == CH_RD_HIT)),
        .all_out(read_hit_delay_all_out)
    );
    delay_line #(.DEPTH(M)) u_read_miss (
        .clk(clk), .rst(rst), .din(start & (sel == CH_RD_MISS)),
        .all_out(read_miss_delay_all_out)
    );
    delay_line #(.DEPTH(H)) u_write_hit (
        .clk(clk), .rst(rst), .din(start & (sel == CH_WR_HIT)),
        .all_out(write_hit_delay_all_out)
    );
    delay_line #(.DEPTH(M)) u_write_miss (
        .clk(clk), .rst(rst), .din(start & (sel == CH_WR_MISS)),
        .all_out(write_miss_delay_all_out)
    );

    assign bus.done     = read_hit_delay_all_out[H-1]  | read_miss_delay_all_out[M-1]
                        | write_hit_delay_all_out[H-1] | write_miss_delay_all_out[M-1];
    assign bus.pre_done = read_hit_delay_all_out[H-2]  | read_miss_delay_all_out[M-2]
                        | write_hit_delay_all_out[H-2] | write_miss_delay_all_out[M-2];
endmodule

// File: tb/tb_logic_done_gen.sv
// Directed bench for logic_done_gen with MIN_CYCLES=1 (hit chains 2 deep, miss chains 3 deep).
module tb_logic_done_gen;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   n_done;

    logic_done_gen_if bus ();

    logic_done_gen #(.MIN_CYCLES(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Chain values printed stage0-first, so 3'b100 means stage[0] set.
    task automatic check_state(input string tag, input logic [1:0] rh, input logic [2:0] rm,
                               input logic [1:0] wh, input logic [2:0] wm,
                               input logic pd, input logic dn);
        logic [1:0] a_rh, a_wh;
        logic [2:0] a_rm, a_wm;
        a_rh = {dut.read_hit_delay_all_out[0], dut.read_hit_delay_all_out[1]};
        a_wh = {dut.write_hit_delay_all_out[0], dut.write_hit_delay_all_out[1]};
        a_rm = {dut.read_miss_delay_all_out[0], dut.read_miss_delay_all_out[1],
                dut.read_miss_delay_all_out[2]};
        a_wm = {dut.write_miss_delay_all_out[0], dut.write_miss_delay_all_out[1],
                dut.write_miss_delay_all_out[2]};
        check({tag, ".chains"}, {22'd0, a_rh, a_rm, a_wh, a_wm}, {22'd0, rh, rm, wh, wm});
        check({tag, ".pre_done"}, {31'd0, bus.pre_done}, {31'd0, pd});
        check({tag, ".done"}, {31'd0, bus.done}, {31'd0, dn});
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b0; bus.re = 1'b0; bus.we = 1'b0; bus.hit = 1'b0;

        // 1: reset
        repeat (5) step();
        check_state("reset", 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        check_state("post_reset_idle", 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0);

        // 2: read miss, request dropped right after the accept edge
        bus.re = 1'b1; bus.hit = 1'b0;
        step(); bus.re = 1'b0;
        check_state("rd_miss.t0", 2'b00, 3'b100, 2'b00, 3'b000, 1'b0, 1'b0);
        step();
        check_state("rd_miss.t1", 2'b00, 3'b010, 2'b00, 3'b000, 1'b1, 1'b0);
        step();
        check_state("rd_miss.t2", 2'b00, 3'b001, 2'b00, 3'b000, 1'b0, 1'b1);
        step();
        check_state("rd_miss.idle", 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0);

        // 3: write miss
        bus.we = 1'b1; bus.hit = 1'b0;
        step(); bus.we = 1'b0;
        check_state("wr_miss.t0", 2'b00, 3'b000, 2'b00, 3'b100, 1'b0, 1'b0);
        step();
        check_state("wr_miss.t1", 2'b00, 3'b000, 2'b00, 3'b010, 1'b1, 1'b0);
        step();
        check_state("wr_miss.t2", 2'b00, 3'b000, 2'b00, 3'b001, 1'b0, 1'b1);
        step();

        // 4: read hit
        bus.re = 1'b1; bus.hit = 1'b1;
        step(); bus.re = 1'b0; bus.hit = 1'b0;
        check_state("rd_hit.t0", 2'b10, 3'b000, 2'b00, 3'b000, 1'b1, 1'b0);
        step();
        check_state("rd_hit.t1", 2'b01, 3'b000, 2'b00, 3'b000, 1'b0, 1'b1);
        step();
        check_state("rd_hit.idle", 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0);

        // 5: write hit
        bus.we = 1'b1; bus.hit = 1'b1;
        step(); bus.we = 1'b0; bus.hit = 1'b0;
        check_state("wr_hit.t0", 2'b00, 3'b000, 2'b10, 3'b000, 1'b1, 1'b0);
        step();
        check_state("wr_hit.t1", 2'b00, 3'b000, 2'b01, 3'b000, 1'b0, 1'b1);
        step();

        // 6a: read hit held high -> one accept every 3 cycles
        n_done = 0;
        bus.re = 1'b1; bus.hit = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("hold_hit.pd%0d", i), {31'd0, bus.pre_done}, {31'd0, (i % 3) == 0});
            check($sformatf("hold_hit.dn%0d", i), {31'd0, bus.done}, {31'd0, (i % 3) == 1});
            if (bus.done) n_done++;
        end
        bus.re = 1'b0; bus.hit = 1'b0;
        check("hold_hit.count", n_done, 3);
        step();

        // 6a: read miss held high -> one accept every 4 cycles
        n_done = 0;
        bus.re = 1'b1; bus.hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("hold_miss.pd%0d", i), {31'd0, bus.pre_done}, {31'd0, (i % 4) == 1});
            check($sformatf("hold_miss.dn%0d", i), {31'd0, bus.done}, {31'd0, (i % 4) == 2});
            if (bus.done) n_done++;
        end
        bus.re = 1'b0;
        check("hold_miss.count", n_done, 2);
        step();

        // New request while busy is ignored
        bus.re = 1'b1;
        step(); bus.re = 1'b0; bus.we = 1'b1; bus.hit = 1'b1;
        step(); bus.we = 1'b0; bus.hit = 1'b0;
        check_state("busy_ignore.t1", 2'b00, 3'b010, 2'b00, 3'b000, 1'b1, 1'b0);
        step();
        check_state("busy_ignore.t2", 2'b00, 3'b001, 2'b00, 3'b000, 1'b0, 1'b1);
        step();
        check_state("busy_ignore.idle", 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0);

        // 6b: re and we together -> read chain only
        bus.re = 1'b1; bus.we = 1'b1; bus.hit = 1'b0;
        step(); bus.re = 1'b0; bus.we = 1'b0;
        check_state("rd_prio.t0", 2'b00, 3'b100, 2'b00, 3'b000, 1'b0, 1'b0);
        repeat (3) step();
        check_state("rd_prio.idle", 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0);

        // 6c: reset mid-miss clears the chain, no done follows
        bus.re = 1'b1; bus.hit = 1'b0;
        step(); bus.re = 1'b0;
        step();
        check_state("rst_mid.t1", 2'b00, 3'b010, 2'b00, 3'b000, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        check_state("rst_mid.cleared", 2'b00, 3'b000, 2'b00, 3'b000, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_mid.no_done%0d", i), {31'd0, bus.done}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
